key_event: RTL and testbench

//  Converts one debounced, synchronised push-button level into single-cycle event

---
 rtl/key_event_if.sv | 34 +++
 rtl/key_event.sv | 157 +++++++++++++++
 tb/tb_key_event.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/key_event_if.sv
// Button-event bundle: debounced level and enable toward key_event, one-cycle
// event strobes and the held level back toward the menu/OSD logic.
interface key_event_if;
  logic level;
  logic enable;
  logic press;
  logic released;
  logic short_click;
  logic long_press;
  logic repeat_pulse;
  logic held;

  modport master (
    output level,
    output enable,
    input  press,
    input  released,
    input  short_click,
    input  long_press,
    input  repeat_pulse,
    input  held
  );

  modport slave (
    input  level,
    input  enable,
    output press,
    output released,
    output short_click,
    output long_press,
    output repeat_pulse,
    output held
  );
endinterface

// File: rtl/key_event.sv
// Push-button event generator: press / release / short click / long press strobes.
// Define KEY_EVENT_REPEAT_EN to add periodic repeat_pulse strobes while held after long_press.
module key_event #(
  parameter int unsigned LONG_CYCLES   = 25_000_000,
  parameter int unsigned REPEAT_CYCLES = 5_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  key_event_if.slave kif
);

`ifdef KEY_EVENT_REPEAT_EN
  localparam bit REPEAT_EN = 1'b1;
`else
  localparam bit REPEAT_EN = 1'b0;
`endif

  localparam int unsigned CNT_MAX =
    (REPEAT_EN && (REPEAT_CYCLES > LONG_CYCLES)) ? REPEAT_CYCLES : LONG_CYCLES;
  localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
`ifdef KEY_EVENT_REPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_HELD,
    S_LONG
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             level_q;
  logic             rise;

  logic press_q, press_n;
  logic release_q, release_n;
  logic short_q, short_n;
  logic long_q, long_n;
  logic held_q, held_n;
`ifdef KEY_EVENT_REPEAT_EN
  logic repeat_q, repeat_n;
`endif

  // level_q resets high so a button held through reset needs a fresh press
  assign rise = kif.level & ~level_q;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    press_n   = 1'b0;
    release_n = 1'b0;
    short_n   = 1'b0;
    long_n    = 1'b0;
`ifdef KEY_EVENT_REPEAT_EN
    repeat_n  = 1'b0;
`endif

    if (!kif.enable) begin
      state_n = S_IDLE;
      cnt_n   = '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (rise) begin
            press_n = 1'b1;
            state_n = S_HELD;
            cnt_n   = '0;
          end
        end

        S_HELD: begin
          if (!kif.level) begin
            release_n = 1'b1;
            short_n   = 1'b1;
            state_n   = S_IDLE;
            cnt_n     = '0;
          end else if (cnt == LONG_LAST) begin
            long_n  = 1'b1;
            state_n = S_LONG;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end

        S_LONG: begin
          // Release takes priority over a repeat falling due on the same cycle
          if (!kif.level) begin
            release_n = 1'b1;
            state_n   = S_IDLE;
            cnt_n     = '0;
`ifdef KEY_EVENT_REPEAT_EN
          end else if (cnt == REPEAT_LAST) begin
            repeat_n = 1'b1;
            cnt_n    = '0;
          end else begin
            cnt_n = cnt + CNT_W'(1);
`endif
          end
        end

        default: begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end
      endcase
    end

    held_n = (state_n != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      level_q   <= 1'b1;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      short_q   <= 1'b0;
      long_q    <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      level_q   <= kif.level;
      press_q   <= press_n;
      release_q <= release_n;
      short_q   <= short_n;
      long_q    <= long_n;
      held_q    <= held_n;
    end
  end

`ifdef KEY_EVENT_REPEAT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      repeat_q <= 1'b0;
    end else begin
      repeat_q <= repeat_n;
    end
  end

  assign kif.repeat_pulse = repeat_q;
`else
  assign kif.repeat_pulse = 1'b0;
`endif

  assign kif.press       = press_q;
  assign kif.released    = release_q;
  assign kif.short_click = short_q;
  assign kif.long_press  = long_q;
  assign kif.held        = held_q;

endmodule

// File: tb/tb_key_event.sv
// Self-checking bench for key_event: directed scenarios then random hold patterns,
// compared each cycle against a press-age reference model.
module tb_key_event;
  localparam int unsigned L = 8;
  localparam int unsigned R = 4;

`ifdef KEY_EVENT_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic clk;
  logic reset_n;
  key_event_if kif ();

  key_event #(
    .LONG_CYCLES  (L),
    .REPEAT_CYCLES(R)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .kif    (kif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned cyc = 0;

  // Reference model: tracks whether a press is active and how many cycles old it is
  bit prev_level;
  bit active;
  int age;
  bit e_press, e_rel, e_short, e_long, e_rep;

  task automatic model_reset();
    prev_level = 1'b1;
    active     = 1'b0;
    age        = 0;
    {e_press, e_rel, e_short, e_long, e_rep} = '0;
  endtask

  task automatic model_edge(input bit lvl, input bit en);
    {e_press, e_rel, e_short, e_long, e_rep} = '0;
    if (!reset_n) begin
      model_reset();
      return;
    end
    if (!en) begin
      active = 1'b0;
    end else if (!active) begin
      if (lvl && !prev_level) begin
        e_press = 1'b1;
        active  = 1'b1;
        age     = 0;
      end
    end else if (!lvl) begin
      e_rel   = 1'b1;
      e_short = (age < int'(L));
      active  = 1'b0;
    end else begin
      age++;
      if (age == int'(L))
        e_long = 1'b1;
      else if (REP && age > int'(L) && ((age - int'(L)) % int'(R)) == 0)
        e_rep = 1'b1;
    end
    prev_level = lvl;
  endtask

  task automatic check(input string tag);
    logic [5:0] obs, exp;
    obs = {kif.press, kif.released, kif.short_click, kif.long_press, kif.repeat_pulse, kif.held};
    exp = {e_press, e_rel, e_short, e_long, e_rep, active};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b (press,rel,short,long,rep,held)",
             tag, cyc, obs, exp);
    end
  endtask

  task automatic step(input bit lvl, input bit en, input string tag);
    kif.level  = lvl;
    kif.enable = en;
    @(posedge clk);
    cyc++;
    model_edge(lvl, en);
    #1;
    check(tag);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, "idle");
  endtask

  initial begin
    kif.level  = 1'b0;
    kif.enable = 1'b1;
    reset_n    = 1'b0;
    model_reset();
    #12;
    check("reset_state");
    reset_n = 1'b1;
    idle(2);

    // Short hold
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, "short_hold");
    step(1'b0, 1'b1, "short_release");
    idle(3);

    // Long hold, repeats at +12 and +16 when enabled
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, "long_hold");
    step(1'b0, 1'b1, "long_release");
    idle(3);

    // Release on the cycle a repeat would fall due
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, "rep_coinc_hold");
    step(1'b0, 1'b1, "rep_coinc_release");
    idle(2);

    // Release exactly when long_press would fall due: still a short click
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, "long_edge_hold");
    step(1'b0, 1'b1, "long_edge_release");
    idle(2);

    // Held through reset
    step(1'b1, 1'b1, "thru_rst_pre");
    #3 reset_n = 1'b0;
    #1 model_reset();
    check("thru_rst_async");
    step(1'b1, 1'b1, "thru_rst_low");
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, "thru_rst_held");
    step(1'b0, 1'b1, "thru_rst_drop");
    step(1'b1, 1'b1, "thru_rst_repress");
    step(1'b0, 1'b1, "thru_rst_rel");
    idle(2);

    // Reset mid-hold
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, "mid_rst_hold");
    #3 reset_n = 1'b0;
    #1 model_reset();
    check("mid_rst_async");
    step(1'b1, 1'b1, "mid_rst_low");
    step(1'b1, 1'b1, "mid_rst_low");
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, "mid_rst_after");
    step(1'b0, 1'b1, "mid_rst_norel");
    idle(2);

    // Enable dropped during hold, then restored with level still high
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, "en_hold");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, "en_off");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, "en_back_high");
    step(1'b0, 1'b1, "en_drop");
    step(1'b1, 1'b1, "en_press");
    step(1'b0, 1'b1, "en_rel");
    idle(2);

    // Random hold/release segments with occasional enable drops
    for (int s = 0; s < 60; s++) begin
      bit lvl;
      int unsigned len;
      lvl = 1'(s % 2 == 0);
      len = lvl ? $urandom_range(1, 24) : $urandom_range(1, 4);
      for (int unsigned i = 0; i < len; i++) begin
        bit en;
        en = ($urandom_range(0, 40) != 0);
        step(lvl, en, "random");
      end
    end
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
